// File: rtl/dec_rr_arbiter_if.sv
// Bus between the requesters and the round-robin arbiter that drives the 3-to-8 grant decoder.
// Handshake: req[i] is a level held high for as long as requester i wants the resource; the grant
// is dec_e=1 with dec_a=i, and the owner gives the resource back simply by dropping req[i].
interface dec_rr_arbiter_if;
  logic       en;
  logic [7:0] req;
  logic       dec_e;
  logic [2:0] dec_a;
  logic       busy;
  logic       timeout;
  logic [1:0] dbg_state;

  modport master (
    output en,
    output req,
    input  dec_e,
    input  dec_a,
    input  busy,
    input  timeout,
    input  dbg_state
  );

  modport slave (
    input  en,
    input  req,
    output dec_e,
    output dec_a,
    output busy,
    output timeout,
    output dbg_state
  );
endinterface

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter for 8 requesters; registered grant drives the E/A inputs of a 3-to-8 decoder,
// with a forced low gap between owners and an optional hold-time limit.
module dec_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int GAP_CYC  = 1,
  parameter int CNT_W    = 5
) (
  input logic             clk,
  input logic             rst_n,
  dec_rr_arbiter_if.slave io_bus
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_dec_e;
  logic [2:0]       r_dec_a;
  logic             r_busy;
  logic             r_timeout;

  state_t           w_state_nxt;
  logic [2:0]       w_ptr_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [2:0]       w_dec_a_nxt;
  logic             w_timeout_nxt;
  logic             w_dec_e_nxt;
  logic             w_busy_nxt;

  logic             w_pick_vld;
  logic [2:0]       w_pick_idx;
  logic             w_release;
  logic             w_hold_hit;

  // Scan ptr+1 .. ptr+8 (== ptr); walking downward lets the nearest set bit win last.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = r_ptr;
    for (int i = 8; i >= 1; i--) begin
      logic [2:0] cand;
      cand = r_ptr + 3'(i);
      if (io_bus.req[cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = cand;
      end
    end
  end

  assign w_release  = ~io_bus.req[r_dec_a];
  assign w_hold_hit = (HOLD_MAX != 0) && (r_hold_cnt == HOLD_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_dec_a_nxt   = r_dec_a;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.en && w_pick_vld) begin
          w_state_nxt = S_GRANT;
          w_dec_a_nxt = w_pick_idx;
          w_hold_nxt  = '0;
        end
      end
      S_GRANT: begin
        // Release takes precedence, so a coincident timeout is never flagged.
        if (w_release || w_hold_hit) begin
          w_state_nxt   = S_GAP;
          w_ptr_nxt     = r_dec_a;
          w_gap_nxt     = '0;
          w_timeout_nxt = ~w_release;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_dec_e_nxt = (w_state_nxt == S_GRANT);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 3'd7;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_dec_e    <= 1'b0;
      r_dec_a    <= 3'd0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_dec_e    <= w_dec_e_nxt;
      r_dec_a    <= w_dec_a_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign io_bus.dec_e     = r_dec_e;
  assign io_bus.dec_a     = r_dec_a;
  assign io_bus.busy      = r_busy;
  assign io_bus.timeout   = r_timeout;
  assign io_bus.dbg_state = r_state;

endmodule
